// File: rtl/operm_dat_pipe.sv
// Two-stage pipelined lane permuter with valid/ready flow control on both sides.
// S1 registers the raw beat; the permutation mux sits between S1 and S2; S2 drives
// the output lanes together with the beat's control nibble.
module operm_dat_pipe #(
    parameter int unsigned LANES = 16,
    parameter int unsigned DW    = 32,
    localparam int unsigned IW   = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [LANES*DW-1:0]   t_dat_dat,
    input  logic [LANES*IW+3:0]   t_kp_dat,
    input  logic                  t_dat_valid,
    output logic                  t_dat_ready,
    output logic [LANES*DW-1:0]   i_dat_dat,
    output logic                  i_dat_valid,
    input  logic                  i_dat_ready,
    output logic [3:0]            k_ctrl
);

    logic [LANES*DW-1:0] r_s1_dat;
    logic [LANES*IW+3:0] r_s1_kp;
    logic                r_s1_v;
    logic [LANES*DW-1:0] r_s2_dat;
    logic [3:0]          r_s2_ctrl;
    logic                r_s2_v;

    logic                w_s1_load;
    logic                w_s2_load;
    logic [3:0]          w_s1_ctrl;
    logic [IW-1:0]       w_idx0;
    logic [LANES*DW-1:0] w_perm;
    logic [IW-1:0]       w_sel;
    logic [IW:0]         w_sum;
    logic                w_zero;

    // Handshake: room exists unless both stages are full and the output is stalled
    always_comb begin
        t_dat_ready = !r_s1_v || !r_s2_v || i_dat_ready;
        w_s1_load   = t_dat_valid && t_dat_ready;
        w_s2_load   = r_s1_v && (!r_s2_v || i_dat_ready);
        w_s1_ctrl   = r_s1_kp[LANES*IW +: 4];
        w_idx0      = r_s1_kp[0 +: IW];
    end

    // Per-lane source select from the beat held in S1
    always_comb begin
        w_perm = '0;
        w_sel  = '0;
        w_sum  = '0;
        w_zero = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            // One extra bit so the shift mode can see lanes that ran off the top
            w_sum  = {1'b0, IW'(j)} + {1'b0, w_idx0};
            w_zero = 1'b0;
            case (w_s1_ctrl[1:0])
                2'b00: w_sel = r_s1_kp[j*IW +: IW];
                2'b01: w_sel = w_idx0;
                2'b10: begin
                    w_sel  = w_sum[IW-1:0];
                    w_zero = w_s1_ctrl[2] & w_sum[IW];
                end
                default: w_sel = IW'(LANES - 1 - j);
            endcase
            w_perm[j*DW +: DW] = w_zero ? '0 : r_s1_dat[w_sel*DW +: DW];
        end
    end

    // Stage 1: capture the incoming beat on accept, free it when S2 takes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_v   <= 1'b0;
            r_s1_dat <= '0;
            r_s1_kp  <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_v   <= 1'b1;
                r_s1_dat <= t_dat_dat;
                r_s1_kp  <= t_kp_dat;
            end else if (w_s2_load) begin
                r_s1_v <= 1'b0;
            end
        end
    end

    // Stage 2: hold the permuted beat until downstream accepts it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_v    <= 1'b0;
            r_s2_dat  <= '0;
            r_s2_ctrl <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_v    <= 1'b1;
                r_s2_dat  <= w_perm;
                r_s2_ctrl <= w_s1_ctrl;
            end else if (i_dat_ready) begin
                r_s2_v <= 1'b0;
            end
        end
    end

    // Output drive straight from S2
    always_comb begin
        i_dat_valid = r_s2_v;
        i_dat_dat   = r_s2_dat;
        k_ctrl      = r_s2_ctrl;
    end

endmodule

// File: tb/tb_operm_dat_pipe.sv
// Scoreboard bench for operm_dat_pipe (LANES=16, DW=32).
module tb_operm_dat_pipe;

    localparam int L  = 16;
    localparam int W  = 32;
    localparam int DB = L * W;
    localparam int KB = L * 4 + 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DB-1:0] t_dat_dat = '0;
    logic [KB-1:0] t_kp_dat = '0;
    logic          t_dat_valid = 1'b0;
    logic          t_dat_ready;
    logic [DB-1:0] i_dat_dat;
    logic          i_dat_valid;
    logic          i_dat_ready = 1'b1;
    logic [3:0]    k_ctrl;

    typedef struct {
        logic [DB-1:0] dat;
        logic [3:0]    ctrl;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   nout = 0;

    operm_dat_pipe #(.LANES(L), .DW(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .t_dat_dat   (t_dat_dat),
        .t_kp_dat    (t_kp_dat),
        .t_dat_valid (t_dat_valid),
        .t_dat_ready (t_dat_ready),
        .i_dat_dat   (i_dat_dat),
        .i_dat_valid (i_dat_valid),
        .i_dat_ready (i_dat_ready),
        .k_ctrl      (k_ctrl)
    );

    always #5 clk = ~clk;

    function automatic logic [DB-1:0] model(input logic [DB-1:0] d, input logic [KB-1:0] kp);
        logic [3:0] c;
        int src, i0, t;
        c = kp[KB-1 -: 4];
        i0 = int'(kp[3:0]);
        model = '0;
        for (int j = 0; j < L; j++) begin
            case (c[1:0])
                2'd0: src = int'(kp[j*4 +: 4]);
                2'd1: src = i0;
                2'd2: begin
                    t = j + i0;
                    src = (c[2] && t >= L) ? -1 : t % L;
                end
                default: src = L - 1 - j;
            endcase
            if (src >= 0) model[j*W +: W] = d[src*W +: W];
        end
    endfunction

    function automatic logic [DB-1:0] base_dat(input logic [7:0] tag);
        logic [DB-1:0] d;
        for (int k = 0; k < L; k++) d[k*W +: W] = 32'hA000_0000 + 32'(k) + {tag, 16'h0};
        return d;
    endfunction

    function automatic logic [KB-1:0] rand_kp(input logic [3:0] c);
        logic [KB-1:0] kp;
        for (int j = 0; j < L; j++) kp[j*4 +: 4] = 4'($urandom_range(0, 15));
        kp[KB-1 -: 4] = c;
        return kp;
    endfunction

    // Scoreboard: push expected beat on input accept, pop and compare on output accept
    always @(negedge clk) begin
        if (reset_n) begin
            if (i_dat_valid && i_dat_ready) begin
                nout++;
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got dat=%h ctrl=%h, required no beat",
                             i_dat_dat[63:0], k_ctrl);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (i_dat_dat !== e.dat || k_ctrl !== e.ctrl) begin
                        fails++;
                        $display("FAIL sb_beat: got lo=%h ctrl=%h, required lo=%h ctrl=%h",
                                 i_dat_dat[63:0], k_ctrl, e.dat[63:0], e.ctrl);
                    end
                end
            end
            if (t_dat_valid && t_dat_ready) begin
                exp_t n;
                n.dat = model(t_dat_dat, t_kp_dat);
                n.ctrl = t_kp_dat[KB-1 -: 4];
                sbq.push_back(n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait for accept, then wait for it at the output; lat counts
    // negedges after the accepting edge. Returns on the negedge where output is valid.
    task automatic beat_and_wait(input logic [DB-1:0] d, input logic [KB-1:0] kp,
                                 output int lat);
        int n;
        t_dat_dat = d;
        t_kp_dat = kp;
        t_dat_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!t_dat_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got ready=0 for 20 cycles, required accept");
        end
        tick();
        t_dat_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!i_dat_valid && lat < 20);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tests += 4;
        if (i_dat_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b required 0", i_dat_valid); end
        if (i_dat_dat !== '0) begin fails++; $display("FAIL rst_dat: got %h required 0", i_dat_dat[63:0]); end
        if (k_ctrl !== 4'h0) begin fails++; $display("FAIL rst_ctrl: got %h required 0", k_ctrl); end
        if (t_dat_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b required 1", t_dat_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_modes();
        logic [DB-1:0] d;
        logic [KB-1:0] kp;
        int lat;
        d = base_dat(8'h00);
        i_dat_ready = 1'b1;

        // identity gather
        kp = '0;
        for (int j = 0; j < L; j++) kp[j*4 +: 4] = 4'(j);
        beat_and_wait(d, kp, lat);
        tests += 3;
        if (lat != 2) begin fails++; $display("FAIL ident_latency: got %0d required 2", lat); end
        if (i_dat_dat !== d) begin fails++; $display("FAIL ident_dat: got %h required %h", i_dat_dat[63:0], d[63:0]); end
        if (k_ctrl !== 4'h0) begin fails++; $display("FAIL ident_ctrl: got %h required 0", k_ctrl); end
        tick();

        // reversed gather with user flag
        for (int j = 0; j < L; j++) kp[j*4 +: 4] = 4'(15 - j);
        kp[KB-1 -: 4] = 4'b1000;
        beat_and_wait(d, kp, lat);
        tests += 3;
        if (i_dat_dat[0 +: W] !== 32'hA000_000F) begin fails++; $display("FAIL rev_lane0: got %h required a000000f", i_dat_dat[0 +: W]); end
        if (i_dat_dat[15*W +: W] !== 32'hA000_0000) begin fails++; $display("FAIL rev_lane15: got %h required a0000000", i_dat_dat[15*W +: W]); end
        if (k_ctrl !== 4'b1000) begin fails++; $display("FAIL rev_ctrl: got %h required 8", k_ctrl); end
        tick();

        // reverse mode ignores idx
        kp = rand_kp(4'b0111);
        beat_and_wait(d, kp, lat);
        tests += 2;
        if (i_dat_dat[0 +: W] !== 32'hA000_000F) begin fails++; $display("FAIL m11_lane0: got %h required a000000f", i_dat_dat[0 +: W]); end
        if (i_dat_dat[15*W +: W] !== 32'hA000_0000) begin fails++; $display("FAIL m11_lane15: got %h required a0000000", i_dat_dat[15*W +: W]); end
        tick();

        // broadcast lane 5
        kp = rand_kp(4'b0001);
        kp[3:0] = 4'd5;
        beat_and_wait(d, kp, lat);
        for (int j = 0; j < L; j++) begin
            tests++;
            if (i_dat_dat[j*W +: W] !== 32'hA000_0005) begin
                fails++;
                $display("FAIL bcast_lane%0d: got %h required a0000005", j, i_dat_dat[j*W +: W]);
            end
        end
        tick();

        // rotate by 3
        kp = rand_kp(4'b0010);
        kp[3:0] = 4'd3;
        beat_and_wait(d, kp, lat);
        tests += 2;
        if (i_dat_dat[0 +: W] !== 32'hA000_0003) begin fails++; $display("FAIL rot_lane0: got %h required a0000003", i_dat_dat[0 +: W]); end
        if (i_dat_dat[13*W +: W] !== 32'hA000_0000) begin fails++; $display("FAIL rot_lane13: got %h required a0000000", i_dat_dat[13*W +: W]); end
        tick();

        // shift by 3 with zero fill
        kp[KB-1 -: 4] = 4'b0110;
        beat_and_wait(d, kp, lat);
        tests += 4;
        if (i_dat_dat[12*W +: W] !== 32'hA000_000F) begin fails++; $display("FAIL shf_lane12: got %h required a000000f", i_dat_dat[12*W +: W]); end
        for (int j = 13; j < L; j++) begin
            if (i_dat_dat[j*W +: W] !== 32'h0) begin
                fails++;
                $display("FAIL shf_lane%0d: got %h required 0", j, i_dat_dat[j*W +: W]);
            end
        end
        tick();
        repeat (2) tick();
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        int out0;
        pat = 4'b1001;  // ready sequence 1,0,0,1 (bit 0 first)
        out0 = nout;
        i_dat_ready = pat[0];
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    int n;
                    t_dat_dat = base_dat(8'(b + 1));
                    t_kp_dat = rand_kp(4'($urandom_range(0, 15)));
                    t_dat_valid = 1'b1;
                    n = 0;
                    @(negedge clk);
                    while (!t_dat_ready && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= 20) begin
                        tests++;
                        fails++;
                        $display("FAIL stall_accept: got ready=0 for 20 cycles, required accept");
                    end
                    tick();
                end
                t_dat_valid = 1'b0;
            end
            begin
                int occ;
                logic          pv;
                logic [DB-1:0] pd;
                logic [3:0]    pc;
                occ = 0;
                pv = 1'b0;
                pd = '0;
                pc = '0;
                for (int cyc = 0; cyc < 48; cyc++) begin
                    @(negedge clk);
                    tests++;
                    if (t_dat_ready !== !(occ == 2 && !i_dat_ready)) begin
                        fails++;
                        $display("FAIL stall_ready c%0d: got %b required %b (held %0d)",
                                 cyc, t_dat_ready, !(occ == 2 && !i_dat_ready), occ);
                    end
                    if (pv) begin
                        tests++;
                        if (i_dat_valid !== 1'b1 || i_dat_dat !== pd || k_ctrl !== pc) begin
                            fails++;
                            $display("FAIL stall_hold c%0d: got v=%b lo=%h ctrl=%h, required v=1 lo=%h ctrl=%h",
                                     cyc, i_dat_valid, i_dat_dat[63:0], k_ctrl, pd[63:0], pc);
                        end
                    end
                    pv = i_dat_valid && !i_dat_ready;
                    pd = i_dat_dat;
                    pc = k_ctrl;
                    occ += (t_dat_valid && t_dat_ready) ? 1 : 0;
                    occ -= (i_dat_valid && i_dat_ready) ? 1 : 0;
                    tick();
                    i_dat_ready = pat[(cyc + 1) % 4];
                end
            end
        join
        i_dat_ready = 1'b1;
        repeat (4) tick();
        tests += 2;
        if (nout - out0 != 8) begin fails++; $display("FAIL stall_count: got %0d beats required 8", nout - out0); end
        if (sbq.size() != 0) begin fails++; $display("FAIL stall_pending: got %0d left required 0", sbq.size()); end
    endtask

    task automatic test_back_to_back();
        int out0;
        out0 = nout;
        i_dat_ready = 1'b1;
        fork
            begin
                for (int b = 0; b < 6; b++) begin
                    t_dat_dat = base_dat(8'(b + 16));
                    t_kp_dat = rand_kp(4'($urandom_range(0, 15)));
                    t_dat_valid = 1'b1;
                    @(negedge clk);
                    tests++;
                    if (t_dat_ready !== 1'b1) begin
                        fails++;
                        $display("FAIL b2b_ready beat%0d: got %b required 1", b, t_dat_ready);
                    end
                    tick();
                end
                t_dat_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!i_dat_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                tests++;
                if (n != 2) begin fails++; $display("FAIL b2b_fill: got first valid after %0d extra cycles required 2", n); end
                for (int k = 1; k < 6; k++) begin
                    @(negedge clk);
                    tests++;
                    if (i_dat_valid !== 1'b1) begin
                        fails++;
                        $display("FAIL b2b_bubble beat%0d: got valid=%b required 1", k, i_dat_valid);
                    end
                end
            end
        join
        repeat (4) tick();
        tests++;
        if (nout - out0 != 6) begin fails++; $display("FAIL b2b_count: got %0d beats required 6", nout - out0); end
    endtask

    task automatic test_reset_mid();
        logic [DB-1:0] d;
        logic [KB-1:0] kp;
        int lat, out0;
        i_dat_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            t_dat_dat = base_dat(8'(b + 32));
            t_kp_dat = rand_kp(4'b0000);
            t_dat_valid = 1'b1;
            tick();
        end
        t_dat_valid = 1'b0;
        tick();
        tests += 2;
        if (i_dat_valid !== 1'b1) begin fails++; $display("FAIL mid_full_valid: got %b required 1", i_dat_valid); end
        if (t_dat_ready !== 1'b0) begin fails++; $display("FAIL mid_full_ready: got %b required 0", t_dat_ready); end
        #2;
        reset_n = 1'b0;
        #1;
        sbq.delete();
        tests += 3;
        if (i_dat_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b required 0", i_dat_valid); end
        if (i_dat_dat !== '0) begin fails++; $display("FAIL mid_rst_dat: got %h required 0", i_dat_dat[63:0]); end
        if (t_dat_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready: got %b required 1", t_dat_ready); end
        i_dat_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        out0 = nout;
        d = base_dat(8'h55);
        kp = '0;
        for (int j = 0; j < L; j++) kp[j*4 +: 4] = 4'(j);
        kp[KB-1 -: 4] = 4'b1000;
        beat_and_wait(d, kp, lat);
        tests += 3;
        if (lat != 2) begin fails++; $display("FAIL post_rst_latency: got %0d required 2", lat); end
        if (i_dat_dat !== d) begin fails++; $display("FAIL post_rst_dat: got %h required %h", i_dat_dat[63:0], d[63:0]); end
        if (k_ctrl !== 4'b1000) begin fails++; $display("FAIL post_rst_ctrl: got %h required 8", k_ctrl); end
        repeat (8) tick();
        tests++;
        if (nout - out0 != 1) begin fails++; $display("FAIL post_rst_count: got %0d beats required 1", nout - out0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_modes();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operm_dat_pipe.md
# operm_dat_pipe

Parametrised, pipelined lane permuter for the piston datapath: gathers LANES words of DW bits into a new lane order selected per lane by a packed index vector, with broadcast, rotate/shift and reverse modes. It is the registered, flow-controlled successor of the fixed 16x32 combinational permuter. It sits between the operand fetch stream and the execution lanes, with valid/ready handshakes on both sides and the control nibble kept aligned with its data.

## Interface
- LANES, 16, lane count; power of two, >= 2.
- DW, 32, bits per lane.
- IW (localparam), $clog2(LANES), index width per lane.
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- t_dat_dat  in  LANES*DW  input lanes; lane k at [k*DW +: DW].
- t_kp_dat  in  LANES*IW+4  lane indices idx[j] at [j*IW +: IW]; ctrl = top 4 bits.
- t_dat_valid  in  1  input beat valid; data and kp travel as one beat.
- t_dat_ready  out  1  input beat accepted when valid && ready.
- i_dat_dat  out  LANES*DW  permuted lanes.
- i_dat_valid  out  1  output beat valid.
- i_dat_ready  in  1  downstream accept.
- k_ctrl  out  4  ctrl of the beat currently on i_dat_dat.

## Operation
- ctrl[1:0] mode; ctrl[2] shift-fill; ctrl[3] user flag, passed through only.
- Mode 00 gather: out[j] = in[idx[j]].
- Mode 01 broadcast: out[j] = in[idx[0]] for all j.
- Mode 10 rotate: s = (j + idx[0]) mod LANES; out[j] = in[s]. If ctrl[2]=1 and j + idx[0] >= LANES, out[j] = 0 (shift toward lane 0, zero fill). Sum computed IW+1 bits wide.
- Mode 11 reverse: out[j] = in[LANES-1-j]; idx ignored.
- ctrl[2] ignored in modes 00, 01, 11.
- Two register stages. S1 captures {t_dat_dat, t_kp_dat} on accept. S2 holds the computed permutation and ctrl. The mux sits between S1 and S2.
- Stage valid bits s1_v, s2_v. S2 loads when s1_v && (!s2_v || i_dat_ready). S1 loads when t_dat_valid && t_dat_ready.
- t_dat_ready = !s1_v || !s2_v || i_dat_ready. This is combinational from i_dat_ready, with no loop through t_dat_valid.
- i_dat_valid = s2_v. i_dat_dat and k_ctrl hold stable while i_dat_valid && !i_dat_ready.
- Beats exit in order. No beat is dropped or duplicated.

## Timing
- Reset (async assert, sync release internally acceptable): s1_v=0, s2_v=0, i_dat_valid=0, i_dat_dat=0, k_ctrl=0, t_dat_ready=1.
- Latency: a beat accepted at edge N appears with i_dat_valid=1 after edge N+1, i.e. 2 cycles from presentation.
- Throughput: 1 beat/cycle while i_dat_ready=1.
- Full: s1_v && s2_v && !i_dat_ready drives t_dat_ready=0. Capacity is 2 beats.
- Simultaneous drain and fill: while full, i_dat_ready=1 lets S2 take S1 and S1 take the new input in the same edge.
- Empty: i_dat_valid=0. i_dat_dat holds its last value, don't-care.
- Mid-operation reset discards all in-flight beats immediately. The first beat after release follows the normal 2-cycle latency.
- Index wrap: rotate wraps mod LANES. idx values are always in range by width.

## Test plan
- LANES=16, DW=32, lane k = 32'hA000_0000+k, mode 00, idx[j]=j -> output lane j = A000_000j, k_ctrl=0, valid 2 cycles after accept.
- Mode 00, idx[j]=15-j, ctrl[3]=1 -> lane 0 = A000_000F, lane 15 = A000_0000, k_ctrl=4'b1000. Mode 11 with random idx gives the same data.
- Mode 01, idx[0]=5 -> all 16 lanes = A000_0005. Mode 10, idx[0]=3, ctrl[2]=0 -> lane 0 = A000_0003, lane 13 = A000_0000. Same with ctrl[2]=1 -> lanes 13..15 = 0.
- Stream 8 beats with i_dat_ready toggling 1,0,0,1,... -> t_dat_ready=0 only when 2 beats are held. Outputs are stable under stall. All 8 beats arrive in order with matching k_ctrl.
- Continuous valid with i_dat_ready=1 -> one output per cycle, no bubbles after the first 2-cycle fill.
- Assert reset_n=0 with 2 beats held -> i_dat_valid=0 and i_dat_dat=0 immediately. After release, the next beat emerges 2 cycles after accept and the old beats never reappear.
